// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared slot type, width defaults and saturation constant for hazard_scoreboard
package hazard_pkg;

  localparam int DEF_REG_ADDR_W = 2;
  localparam int DEF_PC_W       = 16;
  localparam int DEF_CNT_W      = 16;
  localparam int SLOT_DEST_W    = 8;

  // Sliced down to the counter width by each counter instance.
  localparam logic [63:0] CNT_SAT_ALL_ONES = '1;

  typedef logic [SLOT_DEST_W-1:0] slot_dest_t;

  typedef struct packed {
    logic       valid;
    slot_dest_t dest;
    logic       is_load;
  } slot_t;

  function automatic logic src_hit(input logic id_valid, input logic use_src,
                                   input slot_dest_t src, input slot_t slot);
    return id_valid & use_src & slot.valid & (src == slot.dest);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with enable and synchronous active-high reset
module sat_counter
  import hazard_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] SAT = CNT_SAT_ALL_ONES[CNT_W-1:0];
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_en && (r_count != SAT)) begin
      r_count <= r_count + ONE;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - shadow IDEX/EXMEM/MEMWB slots raising data, jump and branch hazards
// Define HAZARD_FORWARDING_EN to restrict ID_data_hazard to load-use against S_EX.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int PC_W       = DEF_PC_W,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ID_valid,
  input  logic                  ID_rs_use,
  input  logic                  ID_rt_use,
  input  logic [REG_ADDR_W-1:0] ID_rs,
  input  logic [REG_ADDR_W-1:0] ID_rt,
  input  logic                  ID_writes_reg,
  input  logic [REG_ADDR_W-1:0] ID_dest,
  input  logic                  ID_is_load,
  input  logic                  ID_is_jump,
  input  logic [PC_W-1:0]       ID_jump_target,
  input  logic [PC_W-1:0]       IF_pc,
  input  logic                  EX_valid,
  input  logic                  EX_is_branch,
  input  logic                  EX_taken,
  input  logic                  EX_pred_taken,
  input  logic [PC_W-1:0]       EX_target,
  input  logic [PC_W-1:0]       EX_pred_target,
  input  logic [PC_W-1:0]       EX_pc_plus1,
  input  logic                  IFID_stall,
  input  logic                  IDEX_stall,
  input  logic                  EXMEM_stall,
  input  logic                  MEMWB_stall,
  input  logic                  IDEX_flush,
  input  logic                  EXMEM_flush,
  input  logic                  MEMWB_flush,
  input  logic                  WB_is_halted,
  output logic                  ID_data_hazard,
  output logic                  Jump_Failed,
  output logic                  Branch_Failed,
  output logic [PC_W-1:0]       EX_correct_pc,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      mispredicts
);

`ifdef HAZARD_FORWARDING_EN
  localparam logic FWD_EN = 1'b1;
`else
  localparam logic FWD_EN = 1'b0;
`endif

  slot_t r_s_ex, r_s_mem, r_s_wb;
  slot_t w_id_slot;
  logic  w_hit_ex, w_hit_mem, w_hit_wb;
  logic  w_stall_en, w_mispredict_en;

  always_comb begin
    w_id_slot         = '0;
    w_id_slot.valid   = ID_valid & ID_writes_reg;
    w_id_slot.dest    = slot_dest_t'(ID_dest);
    w_id_slot.is_load = ID_is_load;
  end

  // Flush beats stall; a halted machine freezes every slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s_ex  <= '0;
      r_s_mem <= '0;
      r_s_wb  <= '0;
    end else if (!WB_is_halted) begin
      if (IDEX_flush)                     r_s_ex.valid <= 1'b0;
      else if (!IDEX_stall && !IFID_stall) r_s_ex       <= w_id_slot;

      if (EXMEM_flush)       r_s_mem.valid <= 1'b0;
      else if (!EXMEM_stall) r_s_mem       <= r_s_ex;

      if (MEMWB_flush)       r_s_wb.valid <= 1'b0;
      else if (!MEMWB_stall) r_s_wb       <= r_s_mem;
    end
  end

  assign w_hit_ex  = src_hit(ID_valid, ID_rs_use, slot_dest_t'(ID_rs), r_s_ex)
                   | src_hit(ID_valid, ID_rt_use, slot_dest_t'(ID_rt), r_s_ex);
  assign w_hit_mem = src_hit(ID_valid, ID_rs_use, slot_dest_t'(ID_rs), r_s_mem)
                   | src_hit(ID_valid, ID_rt_use, slot_dest_t'(ID_rt), r_s_mem);
  assign w_hit_wb  = src_hit(ID_valid, ID_rs_use, slot_dest_t'(ID_rs), r_s_wb)
                   | src_hit(ID_valid, ID_rt_use, slot_dest_t'(ID_rt), r_s_wb);

  // The register file has no write-through, so a WB-stage producer still blocks without forwarding.
  assign ID_data_hazard = (w_hit_ex & (~FWD_EN | r_s_ex.is_load))
                        | (~FWD_EN & (w_hit_mem | w_hit_wb));

  assign Jump_Failed   = ID_valid & ID_is_jump & (ID_jump_target != IF_pc);
  assign Branch_Failed = EX_valid & EX_is_branch &
                         ((EX_taken != EX_pred_taken) | (EX_taken & (EX_target != EX_pred_target)));
  assign EX_correct_pc = EX_taken ? EX_target : EX_pc_plus1;

  assign w_stall_en      = ID_data_hazard & ~Branch_Failed & ~WB_is_halted;
  assign w_mispredict_en = (Branch_Failed | (Jump_Failed & ~ID_data_hazard)) & ~WB_is_halted;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .i_clk   (clk),
    .i_reset (reset),
    .i_en    (w_stall_en),
    .o_count (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_mispredict_cnt (
    .i_clk   (clk),
    .i_reset (reset),
    .i_en    (w_mispredict_en),
    .o_count (mispredicts)
  );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        ID_valid, ID_rs_use, ID_rt_use, ID_writes_reg, ID_is_load, ID_is_jump;
  logic [1:0]  ID_rs, ID_rt, ID_dest;
  logic [15:0] ID_jump_target, IF_pc;
  logic        EX_valid, EX_is_branch, EX_taken, EX_pred_taken;
  logic [15:0] EX_target, EX_pred_target, EX_pc_plus1;
  logic        IFID_stall, IDEX_stall, EXMEM_stall, MEMWB_stall;
  logic        IDEX_flush, EXMEM_flush, MEMWB_flush, WB_is_halted;
  logic        ID_data_hazard, Jump_Failed, Branch_Failed;
  logic [15:0] EX_correct_pc, stall_cycles, mispredicts;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset),
    .ID_valid(ID_valid), .ID_rs_use(ID_rs_use), .ID_rt_use(ID_rt_use),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_writes_reg(ID_writes_reg), .ID_dest(ID_dest),
    .ID_is_load(ID_is_load), .ID_is_jump(ID_is_jump), .ID_jump_target(ID_jump_target),
    .IF_pc(IF_pc), .EX_valid(EX_valid), .EX_is_branch(EX_is_branch), .EX_taken(EX_taken),
    .EX_pred_taken(EX_pred_taken), .EX_target(EX_target), .EX_pred_target(EX_pred_target),
    .IFID_stall(IFID_stall), .IDEX_stall(IDEX_stall), .EXMEM_stall(EXMEM_stall),
    .MEMWB_stall(MEMWB_stall), .IDEX_flush(IDEX_flush), .EXMEM_flush(EXMEM_flush),
    .MEMWB_flush(MEMWB_flush), .WB_is_halted(WB_is_halted),
    .ID_data_hazard(ID_data_hazard), .Jump_Failed(Jump_Failed), .Branch_Failed(Branch_Failed),
    .EX_correct_pc(EX_correct_pc), .EX_pc_plus1(EX_pc_plus1),
    .stall_cycles(stall_cycles), .mispredicts(mispredicts)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ID_valid = 0; ID_rs_use = 0; ID_rt_use = 0; ID_writes_reg = 0; ID_is_load = 0; ID_is_jump = 0;
    ID_rs = 0; ID_rt = 0; ID_dest = 0; ID_jump_target = 0; IF_pc = 0;
    EX_valid = 0; EX_is_branch = 0; EX_taken = 0; EX_pred_taken = 0;
    EX_target = 0; EX_pred_target = 0; EX_pc_plus1 = 0;
    IFID_stall = 0; IDEX_stall = 0; EXMEM_stall = 0; MEMWB_stall = 0;
    IDEX_flush = 0; EXMEM_flush = 0; MEMWB_flush = 0; WB_is_halted = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic drive_producer(input logic [1:0] dest, input logic is_load);
    clear_inputs();
    ID_valid = 1; ID_writes_reg = 1; ID_dest = dest; ID_is_load = is_load;
  endtask

  task automatic drive_user(input logic [1:0] src, input logic use_rt);
    clear_inputs();
    ID_valid = 1;
    if (use_rt) begin ID_rt_use = 1; ID_rt = src; end
    else        begin ID_rs_use = 1; ID_rs = src; end
  endtask

  // Per-cycle expected hazard after the producer leaves ID (bit i = cycle i).
`ifdef HAZARD_FORWARDING_EN
  logic [3:0] exp_add = 4'b0000;
  logic [3:0] exp_lwd = 4'b0001;
  logic [15:0] exp_add_stalls = 16'd0;
  logic [15:0] exp_lwd_stalls = 16'd1;
`else
  logic [3:0] exp_add = 4'b0111;
  logic [3:0] exp_lwd = 4'b0111;
  logic [15:0] exp_add_stalls = 16'd3;
  logic [15:0] exp_lwd_stalls = 16'd3;
`endif

  initial begin
    clear_inputs();
    reset = 1;
    step();
    drive_user(2'd0, 1'b0);
    #1;
    check("reset_hazard", ID_data_hazard, 0);
    check("reset_stalls", stall_cycles, 0);
    check("reset_mispred", mispredicts, 0);
    reset = 0;

    // ADD R1 then reader of rs=R1, no stalls injected
    do_reset();
    drive_producer(2'd1, 1'b0);
    #1 check("add_prod_hazard", ID_data_hazard, 0);
    step();
    drive_user(2'd1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("add_hazard_c%0d", i), ID_data_hazard, exp_add[i]);
      step();
    end
    check("add_stalls", stall_cycles, exp_add_stalls);
    check("add_mispred", mispredicts, 0);

    // LWD R2 then reader of rt=R2
    do_reset();
    drive_producer(2'd2, 1'b1);
    step();
    drive_user(2'd2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("lwd_hazard_c%0d", i), ID_data_hazard, exp_lwd[i]);
      step();
    end
    check("lwd_stalls", stall_cycles, exp_lwd_stalls);

    // Jump misprediction
    do_reset();
    ID_valid = 1; ID_is_jump = 1; ID_jump_target = 16'h0040; IF_pc = 16'h0011;
    #1 check("jmp_fail", Jump_Failed, 1);
    step();
    check("jmp_mispred", mispredicts, 1);
    IF_pc = 16'h0040;
    #1 check("jmp_ok", Jump_Failed, 0);
    step();
    check("jmp_ok_mispred", mispredicts, 1);

    // Branch misprediction
    clear_inputs();
    EX_valid = 1; EX_is_branch = 1; EX_taken = 1; EX_pred_taken = 0;
    EX_target = 16'h0020; EX_pred_target = 16'h0000; EX_pc_plus1 = 16'h0031;
    #1 check("br_fail", Branch_Failed, 1);
    check("br_correct_pc", EX_correct_pc, 16'h0020);
    step();
    check("br_mispred", mispredicts, 2);
    EX_taken = 0; EX_pred_taken = 0;
    #1 check("br_ok", Branch_Failed, 0);
    check("br_ok_pc", EX_correct_pc, 16'h0031);
    EX_taken = 1; EX_pred_taken = 1; EX_pred_target = 16'h0021;
    #1 check("br_tgt_fail", Branch_Failed, 1);
    EX_pred_target = 16'h0020;
    #1 check("br_tgt_ok", Branch_Failed, 0);
    step();
    check("br_ok_mispred", mispredicts, 2);

    // Halt freezes a pending load-use hazard and the counters
    do_reset();
    drive_producer(2'd3, 1'b1);
    step();
    drive_user(2'd3, 1'b0);
    WB_is_halted = 1;
    #1 check("halt_hazard_pre", ID_data_hazard, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("halt_hazard_c%0d", i), ID_data_hazard, 1);
      check($sformatf("halt_stalls_c%0d", i), stall_cycles, 0);
    end
    WB_is_halted = 0;
    reset = 1;
    step();
    reset = 0;
    #1 check("rst_mid_hazard", ID_data_hazard, 0);
    check("rst_mid_stalls", stall_cycles, 0);
    check("rst_mid_mispred", mispredicts, 0);

    // Saturation via a long held load-use stall
    do_reset();
    drive_producer(2'd1, 1'b1);
    step();
    drive_user(2'd1, 1'b0);
    IDEX_stall = 1;
    repeat (65534) step();
    check("sat_fffe", stall_cycles, 16'hFFFE);
    check("sat_hazard", ID_data_hazard, 1);
    repeat (2) step();
    check("sat_ffff", stall_cycles, 16'hFFFF);
    step();
    check("sat_hold", stall_cycles, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Producer side of the pipeline hazard-control interface: tracks in-flight register writes across the IDEX/EXMEM/MEMWB pipeline registers and raises `ID_data_hazard`, `Jump_Failed` and `Branch_Failed` toward the hazard handler. It consumes the handler's stall/flush outputs to keep its shadow pipeline aligned with the real one. It also keeps saturating performance counters for stall cycles and mispredictions. The block sits in the TSC pipelined CPU beside the ID stage, with the EX stage feeding it branch-resolution data.

## Interface
- `REG_ADDR_W`, default 2: register specifier width (4 GPRs).
- `PC_W`, default 16: PC/target width.
- `CNT_W`, default 16: performance counter width.
- `clk`  in  1  clock; all state changes on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `ID_valid`  in  1  ID holds a real instruction, not a bubble.
- `ID_rs_use`, `ID_rt_use`  in  1 each  instruction reads rs/rt.
- `ID_rs`, `ID_rt`  in  REG_ADDR_W each  source specifiers.
- `ID_writes_reg`  in  1  instruction writes a GPR.
- `ID_dest`  in  REG_ADDR_W  destination specifier.
- `ID_is_load`  in  1  instruction is LWD.
- `ID_is_jump`  in  1  JMP/JAL/JPR/JRL resolved in ID.
- `ID_jump_target`  in  PC_W  resolved jump target.
- `IF_pc`  in  PC_W  PC of the instruction now in IF (the predicted successor).
- `EX_valid`, `EX_is_branch`, `EX_taken`, `EX_pred_taken`  in  1 each  branch resolution in EX.
- `EX_target`, `EX_pred_target`  in  PC_W each  actual and predicted branch targets.
- `IFID_stall`, `IDEX_stall`, `EXMEM_stall`, `MEMWB_stall`, `IDEX_flush`, `EXMEM_flush`, `MEMWB_flush`, `WB_is_halted`  in  1 each  from hazard handler.
- `ID_data_hazard`  out  1  RAW hazard on an ID source.
- `Jump_Failed`  out  1  ID jump target differs from `IF_pc`.
- `Branch_Failed`  out  1  EX branch mispredicted.
- `EX_correct_pc`  out  PC_W  redirect PC: `EX_target` if taken, else `EX_pc_plus1`.
- `EX_pc_plus1`  in  PC_W  fall-through PC of the EX branch.
- `stall_cycles`, `mispredicts`  out  CNT_W each  saturating counters.

## Operation
- Shadow slots S_EX, S_MEM, S_WB, each {valid, dest, is_load}. They mirror IDEX, EXMEM and MEMWB.
- Slot update, each posedge, in priority order:
  - reset: all valid=0.
  - `WB_is_halted`: hold all slots.
  - Otherwise each slot follows its register's control, with flush overriding stall:
    - flush: valid←0.
    - stall: hold.
    - else: load from the upstream slot.
  - S_EX takes {ID_valid & ID_writes_reg, ID_dest, ID_is_load}. If `IFID_stall` is asserted without `IDEX_flush`, S_EX holds.
- Source match: `ID_valid & use & slot.valid & (src == slot.dest)`.
- `ID_data_hazard` is combinational:
  - Without forwarding: any source matches S_EX, S_MEM or S_WB. The register file does not bypass, so S_WB counts.
  - With forwarding: see Configuration.
- `Jump_Failed = ID_valid & ID_is_jump & (ID_jump_target != IF_pc)`.
- `Branch_Failed = EX_valid & EX_is_branch & ((EX_taken != EX_pred_taken) | (EX_taken & (EX_target != EX_pred_target)))`.
- Priority among simultaneous hazards is left to the handler. This block raises every true condition independently.
- `stall_cycles` increments when `ID_data_hazard & ~Branch_Failed & ~WB_is_halted`.
- `mispredicts` increments when `(Branch_Failed | (Jump_Failed & ~ID_data_hazard)) & ~WB_is_halted`.
- Both counters increment at most +1 per cycle and saturate at all-ones.

## Timing
- Hazard outputs and `EX_correct_pc` are purely combinational from current inputs and slot state, with zero latency.
- Reset values:
  - all slot valid bits 0;
  - counters 0;
  - consequently `ID_data_hazard`=0 regardless of ID inputs.
  - `Jump_Failed` and `Branch_Failed` depend only on inputs.
- Stall release: a producer in S_EX clears the hazard in at most 3 cycles without forwarding. With forwarding, a load in S_EX clears it in 1 cycle.
- Reset asserted mid-stall clears slots at that edge. Hazard drops the next cycle.
- When `WB_is_halted` is asserted, slots and counters freeze.

## Configuration
- Macro: `HAZARD_FORWARDING_EN`.
- Defined: `ID_data_hazard` is raised only for load-use, i.e. a match with S_EX where S_EX.is_load=1. Matches against S_MEM/S_WB and non-load S_EX are resolved by forwarding.
- Undefined: full interlock as in Operation.

## Structure
- Shared package, `hazard_pkg`:
  - `slot_t` struct {valid, dest, is_load};
  - `REG_ADDR_W`/`PC_W` defaults;
  - the counter saturation constant.
- One sub-module, `sat_counter` (CNT_W, enable, sync reset), instantiated twice.

## Test plan
- Without forwarding:
  - Drive ADD dest=R1, then ADD src rs=R1 with no stalls injected.
  - Required: `ID_data_hazard`=1 for 3 cycles, then 0.
  - Required: `stall_cycles`=3.
- With `HAZARD_FORWARDING_EN`:
  - Drive LWD dest=R2, then rt=R2 user.
  - Required: hazard=1 for exactly 1 cycle.
  - Repeat with a non-load producer. Required: hazard never asserts.
- Drive JMP with `ID_jump_target`=0x0040, `IF_pc`=0x0011.
  - Required: `Jump_Failed`=1, `mispredicts`=1.
  - Drive `IF_pc`=0x0040. Required: `Jump_Failed`=0.
- Drive BNE `EX_taken`=1, `EX_pred_taken`=0, `EX_target`=0x0020.
  - Required: `Branch_Failed`=1, `EX_correct_pc`=0x0020.
  - Drive not-taken, predicted not-taken. Required: `Branch_Failed`=0.
- Hazard pending, then assert `WB_is_halted` for 4 cycles.
  - Required: slots and counters unchanged during the halt.
  - Then assert `reset` for 1 cycle. Required: hazard=0, counters=0.
- Preload `stall_cycles`=0xFFFE via a long stall.
  - Required: after 2 more stall cycles it reads 0xFFFF and holds.
